// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor-0 block: register numbers, exception codes
// and the processor-ID value used when CP0_PRID_EN is defined.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] PRID_VAL = 32'h2024_0C0D;

endpackage

// File: rtl/cp0_int_arb.sv
// Combinational interrupt/exception arbiter: decides whether the CPU traps this
// cycle and which exception code gets latched into Cause.
module cp0_int_arb
    import cp0_pkg::*;
(
    input  logic [5:0] hw_int,
    input  logic [5:0] im,
    input  logic       ie,
    input  logic       exl,
    input  logic [4:0] exc_code,
    output logic       int_req,
    output logic       exc_req,
    output logic       req,
    output logic [4:0] sel_code
);

    assign int_req  = (|(hw_int & im)) & ie & ~exl;
    assign exc_req  = (exc_code != EXC_INT) & ~exl;
    assign req      = int_req | exc_req;
    // Interrupts outrank a simultaneous synchronous exception.
    assign sel_code = int_req ? EXC_INT : exc_code;

endmodule

// File: rtl/cp0.sv
// Coprocessor-0: SR/Cause/EPC(/PRId) registers and trap request generation.
// Optional macro CP0_PRID_EN makes register 15 read back the processor-ID constant.
module cp0
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC,
    input  logic        BD,
    input  logic [4:0]  ExcCode,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        Req,
    output logic [31:0] EPCOut,
    output logic [31:0] DOut
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic [4:0]  sel_code;

    cp0_int_arb u_arb (
        .hw_int   (HWInt),
        .im       (sr_im),
        .ie       (sr_ie),
        .exl      (sr_exl),
        .exc_code (ExcCode),
        .int_req  (int_req),
        .exc_req  (exc_req),
        .req      (Req),
        .sel_code (sel_code)
    );

    logic [31:0] sr_val;
    logic [31:0] cause_val;

    assign sr_val    = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
    assign cause_val = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};
    assign EPCOut    = epc;

    always_comb begin
        DOut = 32'b0;
        case (A1)
            REG_SR:    DOut = sr_val;
            REG_CAUSE: DOut = cause_val;
            REG_EPC:   DOut = epc;
`ifdef CP0_PRID_EN
            REG_PRID:  DOut = PRID_VAL;
`endif
            default:   DOut = 32'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= HWInt;
            if (Req) begin
                // Taking a trap drops any concurrent mtc0 and eret.
                sr_exl    <= 1'b1;
                cause_exc <= sel_code;
                cause_bd  <= BD;
                epc       <= BD ? (PC - 32'd4) : PC;
            end else begin
                if (EXLClr)
                    sr_exl <= 1'b0;
                // Placed after EXLClr so an explicit SR write decides EXL.
                if (WE && A2 == REG_SR) begin
                    sr_im  <= DIn[15:10];
                    sr_exl <= DIn[1];
                    sr_ie  <= DIn[0];
                end
                if (WE && A2 == REG_EPC)
                    epc <= {DIn[31:2], 2'b00};
            end
        end
    end

endmodule

// File: tb/tb_cp0.sv
// Directed testbench for cp0 with hand-computed expected values.
module tb_cp0;
    import cp0_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] PC;
    logic        BD;
    logic [4:0]  ExcCode;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        Req;
    logic [31:0] EPCOut;
    logic [31:0] DOut;

    int total = 0;
    int bad   = 0;

    cp0 dut (
        .clk     (clk),
        .reset   (reset),
        .A1      (A1),
        .A2      (A2),
        .DIn     (DIn),
        .WE      (WE),
        .PC      (PC),
        .BD      (BD),
        .ExcCode (ExcCode),
        .HWInt   (HWInt),
        .EXLClr  (EXLClr),
        .Req     (Req),
        .EPCOut  (EPCOut),
        .DOut    (DOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
        A1 = a;
        #1;
        chk(tag, DOut, exp);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        WE = 1'b1; A2 = a; DIn = d;
        step();
        WE = 1'b0; A2 = 5'd0; DIn = 32'd0;
    endtask

    logic [31:0] prid_exp;

    initial begin
        reset = 1'b1; A1 = 0; A2 = 0; DIn = 0; WE = 0; PC = 0; BD = 0;
        ExcCode = 0; HWInt = 0; EXLClr = 0;
        step(); step();
        reset = 1'b0;
        #1;

        // Reset state
        rd(REG_SR,    "rst_sr",    32'h0);
        rd(REG_CAUSE, "rst_cause", 32'h0);
        rd(REG_EPC,   "rst_epc",   32'h0);
        chk("rst_req", {31'b0, Req}, 32'h0);

        // Exception RI, no delay slot
        ExcCode = EXC_RI; PC = 32'h3010; #1;
        chk("ri_req", {31'b0, Req}, 32'h1);
        step();
        ExcCode = 0; #1;
        chk("ri_epc", EPCOut, 32'h3010);
        rd(REG_CAUSE, "ri_cause", 32'h28);
        rd(REG_SR,    "ri_sr",    32'h2);
        chk("ri_req_after", {31'b0, Req}, 32'h0);
        ExcCode = EXC_OV; HWInt = 6'h3F; #1;
        chk("exl_sticky", {31'b0, Req}, 32'h0);
        ExcCode = 0; HWInt = 0;

        // SR write masking (also clears EXL), then interrupt in delay slot
        wr(REG_SR, 32'h1234_07FD);
        rd(REG_SR, "sr_mask", 32'h0401);
        chk("sr_noint", {31'b0, Req}, 32'h0);
        HWInt = 6'b000001; PC = 32'h3020; BD = 1'b1; #1;
        chk("int_req", {31'b0, Req}, 32'h1);
        step();
        HWInt = 0; BD = 0; #1;
        chk("int_epc", EPCOut, 32'h301C);
        rd(REG_CAUSE, "int_cause", 32'h8000_0400);
        rd(REG_SR,    "int_sr",    32'h0403);

        // Interrupt wins over simultaneous exception
        wr(REG_SR, 32'h0401);
        HWInt = 6'b000001; ExcCode = EXC_OV; PC = 32'h3030; step();
        HWInt = 0; ExcCode = 0; #1;
        rd(REG_CAUSE, "prio_cause", 32'h0000_0400);

        // EXLClr with interrupt pending: Req on the following cycle
        HWInt = 6'b000001; EXLClr = 1'b1; #1;
        chk("eret_req0", {31'b0, Req}, 32'h0);
        step();
        EXLClr = 1'b0; #1;
        rd(REG_SR, "eret_sr", 32'h0401);
        chk("eret_req1", {31'b0, Req}, 32'h1);
        step();
        HWInt = 0; #1;

        // SR write beats EXLClr
        WE = 1'b1; A2 = REG_SR; DIn = 32'h0402; EXLClr = 1'b1;
        step();
        WE = 0; EXLClr = 0; #1;
        rd(REG_SR, "we_vs_eret", 32'h0402);

        // Req beats EXLClr
        wr(REG_SR, 32'h0401);
        ExcCode = EXC_ADES; EXLClr = 1'b1; PC = 32'h3100; step();
        ExcCode = 0; EXLClr = 0; #1;
        rd(REG_SR, "req_vs_eret", 32'h0403);

        // Req drops a concurrent EPC write
        wr(REG_SR, 32'h0401);
        WE = 1'b1; A2 = REG_EPC; DIn = 32'h3007; ExcCode = EXC_ADEL; PC = 32'h3040;
        #1;
        chk("drop_req", {31'b0, Req}, 32'h1);
        step();
        WE = 0; ExcCode = 0; #1;
        chk("drop_epc", EPCOut, 32'h3040);
        rd(REG_CAUSE, "drop_cause", 32'h10);

        // EPC write without Req, low bits forced to zero
        wr(REG_EPC, 32'h3007);
        chk("epc_wr", EPCOut, 32'h3004);

        // Cause is read-only
        wr(REG_CAUSE, 32'hFFFF_FFFF);
        rd(REG_CAUSE, "cause_ro", 32'h10);

        // Unimplemented and PRId registers
        rd(5'd3, "unimpl", 32'h0);
`ifdef CP0_PRID_EN
        prid_exp = PRID_VAL;
`else
        prid_exp = 32'h0;
`endif
        wr(REG_PRID, 32'hDEAD_BEEF);
        rd(REG_PRID, "prid", prid_exp);

        // EPC wrap in delay slot at PC=0
        wr(REG_SR, 32'h0401);
        ExcCode = EXC_OV; BD = 1'b1; PC = 32'h0; step();
        ExcCode = 0; BD = 0; #1;
        chk("wrap_epc", EPCOut, 32'hFFFF_FFFC);
        rd(REG_CAUSE, "wrap_cause", 32'h8000_0030);

        // Reset wins over a pending Req
        wr(REG_SR, 32'h0401);
        ExcCode = EXC_RI; PC = 32'h3200; reset = 1'b1; #1;
        chk("rstreq_req", {31'b0, Req}, 32'h1);
        step();
        reset = 0; ExcCode = 0; #1;
        rd(REG_SR,    "rstreq_sr",    32'h0);
        rd(REG_CAUSE, "rstreq_cause", 32'h0);
        chk("rstreq_epc", EPCOut, 32'h0);

        // Cause.IP follows HWInt one cycle later, even when masked
        HWInt = 6'h3F; #1;
        chk("ip_req", {31'b0, Req}, 32'h0);
        rd(REG_CAUSE, "ip_before", 32'h0);
        step();
        HWInt = 0; #1;
        rd(REG_CAUSE, "ip_after", 32'h0000_FC00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 exception/interrupt control block; consumes timer `IRQ` lines and the pipeline's exception code, and decides when the CPU takes an exception. Holds SR, Cause, EPC and PRId, is read and written by `mfc0`/`mtc0`, and drives `Req` and `EPCOut` to the pipeline's PC-select and flush logic. Sits at the M stage, directly downstream of the timers (`IRQ` lands on `HWInt`) and the bridge.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the next rising edge.
- `A1`  in  5  read register number for `DOut` (`mfc0`).
- `A2`  in  5  write register number (`mtc0`).
- `DIn`  in  32  write data.
- `WE`  in  1  write enable for `A2`/`DIn`.
- `PC`  in  32  M-stage instruction PC, word-aligned.
- `BD`  in  1  M-stage instruction is in a delay slot.
- `ExcCode`  in  5  M-stage exception code; 0 = none.
- `HWInt`  in  6  external interrupts; bit 0 = timer 0 IRQ, bit 1 = timer 1 IRQ, bit 2 = interrupt generator, 3–5 reserved.
- `EXLClr`  in  1  `eret` in M; clears SR.EXL.
- `Req`  out  1  take exception/interrupt this cycle (combinational).
- `EPCOut`  out  32  EPC register value, the `eret` target.
- `DOut`  out  32  value of register `A1`.

## Operation
- Registers: SR(12) holds IM[15:10], EXL[1], IE[0], all other bits 0. Cause(13) holds BD[31], IP[15:10], ExcCode[6:2], other bits 0, read-only to software. EPC(14) is 32 bits, writable. PRId(15) is covered under Configuration.
- Any other `A1` reads 0; writes to other numbers or to Cause are ignored.
- `mtc0` to SR stores only bits 15:10, 1, 0. `mtc0` to EPC stores `DIn` with bits 1:0 forced to 0.
- Interrupt condition: `IntReq = |(HWInt & SR.IM) & SR.IE & !SR.EXL`.
- Exception condition: `ExcReq = (ExcCode != 0) & !SR.EXL`.
- `Req = IntReq | ExcReq`. Interrupt has priority over exception.
- On a cycle with `Req`=1, at the next edge:
  - SR.EXL <= 1.
  - Cause.ExcCode <= 0 if `IntReq`, else `ExcCode`.
  - Cause.BD <= `BD`.
  - EPC <= `BD` ? `PC`−4 : `PC` (32-bit wrap).
- Cause.IP <= `HWInt` every cycle, independent of `Req`, `WE` and EXL.
- `EXLClr` clears EXL at the next edge.
- Simultaneous events, in priority order:
  - `Req` beats `WE`: the write is dropped entirely.
  - `Req` beats `EXLClr`: EXL ends at 1.
  - `WE` to SR beats `EXLClr`: the written EXL bit is stored.
- `DOut` reads current register contents; no write-to-read bypass.

## Timing
- `Req`, `DOut`, `EPCOut` are combinational from current state and inputs, valid in the same cycle.
- All register updates take effect one edge after the triggering cycle.
- A `HWInt` pulse is visible in Cause.IP one cycle later.
- `Req` depends on live `HWInt`, not on Cause.IP, so `IntReq` reacts with zero latency.
- After reset: SR = Cause = EPC = 0. Interrupts are masked (IE=0). `Req` = 1 only if `ExcCode` ≠ 0.
- Reset asserted while `Req` is high: reset wins and all registers go to 0.
- Sticky level-style: while EXL=1, `Req` stays 0 regardless of `HWInt` or `ExcCode`.

## Configuration
- `CP0_PRID_EN` defined: register 15 reads the constant 32'h2024_0C0D; writes to it are ignored.
- `CP0_PRID_EN` undefined: register 15 is unimplemented and reads 0.

## Structure
- Shared constants header holds:
  - register numbers SR=12, Cause=13, EPC=14, PRId=15;
  - ExcCode values Int=0, AdEL=4, AdES=5, RI=10, Ov=12;
  - the PRId constant.
- One natural sub-module, `cp0_int_arb`: computes `IntReq`, `ExcReq`, `Req` and the selected ExcCode, purely combinational. The top level holds the registers.

## Test plan
- Reset, then `ExcCode`=10, PC=0x3010, BD=0 → `Req`=1 same cycle; next cycle EPC=0x3010, Cause=0x28, SR.EXL=1, `Req`=0.
- `mtc0` SR←0x0401, then `HWInt`=6'b000001, PC=0x3020, BD=1 → `Req`=1; next cycle EPC=0x301C, Cause=0x8000_0400 (BD, IP0, ExcCode 0).
- `HWInt`=1 and `ExcCode`=12 together with SR=0x0401 → Cause.ExcCode=0 (interrupt wins).
- EXL=1, then `EXLClr`=1 with `HWInt`=1 still high and IM0/IE set → EXL=0 after the edge, then `Req`=1 on the following cycle.
- `WE`=1, A2=14, DIn=0x3007 in the same cycle as `Req`=1 from `ExcCode`=4, PC=0x3040 → EPC=0x3040 (write dropped). Without `Req` → EPC=0x3004.
- `A1`=15 → `DOut`=0x2024_0C0D with `CP0_PRID_EN` defined, 0 without it.
